// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and constants for the BCD stopwatch: control
//                state enum, BCD digit width, digit limits, the packed time
//                record and a single-digit BCD increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam int BCD_W = 4;

    localparam logic [BCD_W-1:0] UNITS_MAX = BCD_W'(9);
    localparam logic [BCD_W-1:0] TENS_MAX  = BCD_W'(5);
    localparam logic [BCD_W-1:0] BCD_ONE   = BCD_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    typedef struct packed {
        logic [BCD_W-1:0] min_tens;
        logic [BCD_W-1:0] min_ones;
        logic [BCD_W-1:0] sec_tens;
        logic [BCD_W-1:0] sec_ones;
    } bcd_time_t;

    // Returns {carry_out, next_digit}. A digit at or above its limit rolls to
    // zero with a carry, so an out-of-range value can never persist.
    function automatic logic [BCD_W:0] bcd_step(
        input logic [BCD_W-1:0] digit,
        input logic [BCD_W-1:0] limit,
        input logic             en
    );
        logic [BCD_W:0] result;
        if (!en) begin
            result = {1'b0, digit};
        end else if (digit >= limit) begin
            result = {1'b1, {BCD_W{1'b0}}};
        end else begin
            result = {1'b0, digit + BCD_ONE};
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : tick_sync_edge
//  Description : Synchronises the asynchronous tick square wave into i_clk
//                and turns its transitions into single-cycle count events.
//  Ports       : i_clk          system clock
//                i_reset        asynchronous active-high reset
//                i_tick_toggle  asynchronous tick square wave
//                o_event        one-cycle pulse per detected transition
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_sync_edge #(
    parameter int SYNC_STAGES      = 2,
    parameter int COUNT_BOTH_EDGES = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick_toggle,
    output logic o_event
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   hist_q;
    logic                   hist_d;
    logic                   w_sync_out;

    assign w_sync_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_tick_toggle};
        hist_d = w_sync_out;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    // The event is decoded straight from the last synchroniser stage so the
    // consuming register updates on the SYNC_STAGES-th edge after sampling.
    generate
        if (COUNT_BOTH_EDGES != 0) begin : g_both_edges
            assign o_event = w_sync_out ^ hist_q;
        end else begin : g_rising_only
            assign o_event = w_sync_out & ~hist_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/stopwatch_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_bcd
//  Description : MM:SS BCD stopwatch counting synchronised tick events, with
//                start / stop / clear control and a rollover pulse.
//  Ports       : i_clk, i_reset (async, active-high)
//                i_tick_toggle  slow tick square wave (asynchronous)
//                i_start/i_stop/i_clear  single-cycle control requests
//                o_sec_ones/o_sec_tens/o_min_ones/o_min_tens  BCD digits
//                o_running      high while in RUN
//                o_wrap         one-cycle pulse after 59:59 -> 00:00
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int COUNT_BOTH_EDGES = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tick_toggle,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_clear,
    output logic [BCD_W-1:0] o_sec_ones,
    output logic [BCD_W-1:0] o_sec_tens,
    output logic [BCD_W-1:0] o_min_ones,
    output logic [BCD_W-1:0] o_min_tens,
    output logic             o_running,
    output logic             o_wrap
);

    sw_state_e state_q;
    sw_state_e state_d;
    bcd_time_t time_q;
    bcd_time_t time_d;
    logic      running_q;
    logic      running_d;
    logic      wrap_q;
    logic      wrap_d;

    logic      w_event;
    logic      w_count_en;
    bcd_time_t w_inc_time;
    logic      w_carry_so;
    logic      w_carry_st;
    logic      w_carry_mo;
    logic      w_carry_mt;

    tick_sync_edge #(
        .SYNC_STAGES      (SYNC_STAGES),
        .COUNT_BOTH_EDGES (COUNT_BOTH_EDGES)
    ) u_tick_sync_edge (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_tick_toggle (i_tick_toggle),
        .o_event       (w_event)
    );

    // Ripple-carry BCD cascade; the carry out of the minutes tens digit
    // marks the 59:59 -> 00:00 rollover.
    always_comb begin
        {w_carry_so, w_inc_time.sec_ones} = bcd_step(time_q.sec_ones, UNITS_MAX, 1'b1);
        {w_carry_st, w_inc_time.sec_tens} = bcd_step(time_q.sec_tens, TENS_MAX,  w_carry_so);
        {w_carry_mo, w_inc_time.min_ones} = bcd_step(time_q.min_ones, UNITS_MAX, w_carry_st);
        {w_carry_mt, w_inc_time.min_tens} = bcd_step(time_q.min_tens, TENS_MAX,  w_carry_mo);
    end

    // Clear beats stop beats start. Counting looks at the registered state,
    // so an event arriving together with a start from IDLE/PAUSE is dropped.
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        wrap_d     = 1'b0;
        w_count_en = 1'b0;

        if (i_clear) begin
            state_d = IDLE;
            time_d  = '0;
        end else if (i_stop) begin
            if (state_q == RUN) begin
                state_d = PAUSE;
            end
        end else begin
            if (i_start && (state_q != RUN)) begin
                state_d = RUN;
            end
            w_count_en = w_event && (state_q == RUN);
        end

        if (w_count_en) begin
            time_d = w_inc_time;
            wrap_d = w_carry_mt;
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            time_q    <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
        end
    end

    assign o_sec_ones = time_q.sec_ones;
    assign o_sec_tens = time_q.sec_tens;
    assign o_min_ones = time_q.min_ones;
    assign o_min_tens = time_q.min_tens;
    assign o_running  = running_q;
    assign o_wrap     = wrap_q;

endmodule
`default_nettype wire

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of synchronizer flops on i_tick_toggle (legal 2..4).
REQ-002 Parameter: COUNT_BOTH_EDGES, default 1; 1 = each input transition is one count event, 0 = rising transitions only.
REQ-003 Clock and reset SHALL be: reset i_reset, asynchronous, active-high; clock i_clk.
REQ-004 Ports:
  i_clk  in  1  system clock
  i_reset  in  1  asynchronous active-high reset
  i_tick_toggle  in  1  slow square wave from the upstream divider; level toggles once per tick period
  i_start  in  1  single-cycle start/resume request
  i_stop  in  1  single-cycle pause request
  i_clear  in  1  single-cycle clear request
  o_sec_ones  out  4  BCD seconds units, 0..9
  o_sec_tens  out  4  BCD seconds tens, 0..5
  o_min_ones  out  4  BCD minutes units, 0..9
  o_min_tens  out  4  BCD minutes tens, 0..5
  o_running  out  1  high while state is RUN
  o_wrap  out  1  one-cycle pulse on rollover 59:59 -> 00:00

Function
REQ-005 i_tick_toggle SHALL pass through SYNC_STAGES flops, then one history flop; event = (sync_out XOR history) when COUNT_BOTH_EDGES=1, else (sync_out AND NOT history).
REQ-006 Event latency: digits SHALL update on the SYNC_STAGES-th rising i_clk edge after the edge that first samples the new input level.
REQ-007 FSM states: IDLE, RUN, PAUSE; all outputs registered.
REQ-008 Transitions: IDLE/PAUSE + i_start -> RUN; RUN + i_stop -> PAUSE; any state + i_clear -> IDLE with all digits zeroed; i_start in RUN and i_stop in IDLE/PAUSE are ignored.
REQ-009 Control priority in one cycle: i_clear > i_stop > i_start.
REQ-010 A count event SHALL increment the digits only when the registered state is RUN and neither i_clear nor i_stop is asserted that cycle.
REQ-011 An event coincident with i_start from IDLE/PAUSE SHALL NOT be counted.
REQ-012 Increment: sec_ones 9->0 carries into sec_tens; sec_tens 5->0 carries into min_ones; min_ones 9->0 carries into min_tens; min_tens 5->0 wraps.
REQ-013 On increment from 59:59, all digits SHALL become 0 and o_wrap SHALL be high for exactly the following cycle; counting continues in RUN.
REQ-014 Digits SHALL never hold non-BCD values or values outside the ranges in REQ-004.
REQ-015 PAUSE SHALL hold digits; events in IDLE/PAUSE are discarded, not queued.
REQ-016 Event detection SHALL keep running in all states so that a resume never produces a stale event.

Reset
REQ-017 On i_reset: state IDLE, all digits 0, o_running 0, o_wrap 0, synchronizer and history flops 0.
REQ-018 Reset asserted mid-count SHALL abort immediately; no event or wrap pending from before reset SHALL be counted after release.
REQ-019 A spurious event after release caused by i_tick_toggle=1 SHALL be discarded, because state is IDLE.

Structure
REQ-020 Shared package stopwatch_pkg SHALL hold: state enum (IDLE, RUN, PAUSE), BCD digit width 4, limits UNITS_MAX=9 and TENS_MAX=5.
REQ-021 Synchronizer plus edge detect SHALL be one sub-module, tick_sync_edge (params SYNC_STAGES, COUNT_BOTH_EDGES; out: single-cycle event).
REQ-022 Cascade and FSM SHALL remain in stopwatch_bcd; no derived or gated clocks.

Verification
REQ-023 Start, then 10 toggles of i_tick_toggle spaced 20 clocks -> digits 00:10, o_running=1; first increment exactly 2 clocks after the first sampling edge (SYNC_STAGES=2).
REQ-024 Preload via 3599 events in RUN -> 59:59; one more event -> 00:00 with o_wrap high for exactly 1 cycle.
REQ-025 At 00:05, stop, then 4 toggles, then start, then 1 toggle -> 00:05 held during PAUSE, 00:06 after resume.
REQ-026 Same-cycle i_clear+i_stop+i_start while an event is present at 12:34 -> 00:00, IDLE, o_running=0, no increment.
REQ-027 COUNT_BOTH_EDGES=0, 6 toggles in RUN -> 00:03.
REQ-028 i_reset pulsed asynchronously mid-run at 07:42 with i_tick_toggle=1 -> all outputs 0 immediately; after release, no increment until i_start and a fresh toggle.
